alu_exec_stage: RTL and testbench

Multicycle execute stage that sits directly downstream of the register-file slices. It latches the two operands read out on the A/B ports, performs the decoded ALU operation (single-cycle ops or a 32-iteration shift-add multiply), and presents a write-back word plus destination index. That write-back word feeds the register file's write-data input.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/seq_multiplier.sv | 74 +++++++
 rtl/alu_exec_stage.sv | 151 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute-stage slice: op codes, stage states
// and default datapath sizes.
package cpu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int RIDX_DEF  = 5;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial-product step per cycle, WIDTH steps,
// returning the low WIDTH bits of the unsigned product.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] step_sum;

    assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // done flags the cycle whose closing edge performs the final step, so the
    // consumer can capture product on that same edge.
    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == LAST);
    assign product = step_sum;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start && !busy_q) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Multicycle execute stage: latches operands, runs a single-cycle ALU op or
// the sequential multiplier, then presents one write-back word with its index.
module alu_exec_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RIDX  = RIDX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [RIDX-1:0]  rd_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [RIDX-1:0]  wb_rd,
    output logic             wb_en,
    output logic             zero,
    output logic             ovf
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [RIDX-1:0]  rd_q, rd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [RIDX-1:0]  wb_rd_q, wb_rd_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res, sum, diff;
    logic             alu_ovf;

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a_in),
        .b       (b_in),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        case (op_q)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:   alu_res = a_q & b_q;
            OP_OR:    alu_res = a_q | b_q;
            OP_XOR:   alu_res = a_q ^ b_q;
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLL:   alu_res = a_q << b_q[4:0];
            OP_SRL:   alu_res = a_q >> b_q[4:0];
            OP_SRA:   alu_res = $signed(a_q) >>> b_q[4:0];
            OP_PASSB: alu_res = b_q;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rd_d      = rd_q;
        result_d  = result_q;
        wb_rd_d   = wb_rd_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    op_d      = op;
                    rd_d      = rd_in;
                    mul_start = (op == OP_MUL);
                    state_d   = (op == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                ovf_d    = alu_ovf;
                wb_rd_d  = rd_q;
                state_d  = WB;
            end
            MUL: begin
                if (mul_done) begin
                    result_d = mul_product;
                    zero_d   = (mul_product == '0);
                    ovf_d    = 1'b0;
                    wb_rd_d  = rd_q;
                    state_d  = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            wb_rd_q  <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            wb_rd_q  <= wb_rd_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != IDLE) | mul_busy;
    assign done   = (state_q == WB);
    assign wb_en  = done && (wb_rd_q != '0);
    assign result = result_q;
    assign wb_rd  = wb_rd_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomised scoreboard bench for alu_exec_stage against an arithmetic model.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done, wb_en, zero, ovf;
    logic [31:0] result;
    logic [4:0]  wb_rd;

    alu_exec_stage #(.WIDTH(32), .RIDX(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a_in   (a_in),
        .b_in   (b_in),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wb_rd  (wb_rd),
        .wb_en  (wb_en),
        .zero   (zero),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        z;
        logic        v;
        int          due;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic rst_prev = 1'b1;

    logic [31:0] last_res = 32'd0;
    logic [4:0]  last_rd = 5'd0;
    logic        last_z = 1'b0;
    logic        last_v = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference semantics expressed with wide signed arithmetic.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
        longint s;
        logic [63:0] p;
        r = 32'd0;
        v = 1'b0;
        case (o)
            4'd0: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = a << b[4:0];
            4'd7: r = a >> b[4:0];
            4'd8: r = $signed(a) >>> b[4:0];
            4'd9: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
            end
            4'd10: r = b;
            default: r = 32'd0;
        endcase
    endfunction

    // Monitor: pops one expectation per done pulse and checks hold-stability otherwise.
    always @(negedge clk) begin
        if (rst_prev === 1'b1) begin
            last_res = 32'd0;
            last_rd  = 5'd0;
            last_z   = 1'b0;
            last_v   = 1'b0;
        end else if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("txn op=%0d a=%h b=%h rd=%0d -> result=%h zero=%0b ovf=%0b wb_en=%0b cyc=%0d",
                         e.op, e.a, e.b, e.rd, result, zero, ovf, wb_en, cyc);
                chk("latency", cyc, e.due);
                chk("result", result, e.res);
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("zero", {31'd0, zero}, {31'd0, e.z});
                chk("ovf", {31'd0, ovf}, {31'd0, e.v});
                chk("wb_en", {31'd0, wb_en}, {31'd0, (e.rd != 5'd0)});
                last_res = e.res;
                last_rd  = e.rd;
                last_z   = e.z;
                last_v   = e.v;
            end
        end else begin
            chk("hold_result", result, last_res);
            chk("hold_wb_rd", {27'd0, wb_rd}, {27'd0, last_rd});
            chk("hold_flags", {30'd0, zero, ovf}, {30'd0, last_z, last_v});
            chk("wb_en_idle", {31'd0, wb_en}, 32'd0);
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (busy !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy !== 1'b0) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int interfere);
        exp_t e;
        wait_idle();
        e.op = o;
        e.a  = a;
        e.b  = b;
        e.rd = rd;
        model(o, a, b, e.res, e.v);
        e.z   = (e.res == 32'd0);
        e.due = cyc + ((o == 4'd9) ? 33 : 2);
        q.push_back(e);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        rd_in = rd;
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        rd_in = 5'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        // Requests raised while busy must leave the in-flight op untouched.
        for (int i = 0; i < interfere; i++) begin
            start = 1'b1;
            op    = 4'($urandom_range(0, 15));
            a_in  = $urandom;
            b_in  = $urandom;
            rd_in = 5'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [5];
        c[0] = 32'h0000_0000;
        c[1] = 32'h7FFF_FFFF;
        c[2] = 32'h8000_0000;
        c[3] = 32'hFFFF_FFFF;
        c[4] = 32'h0000_0001;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_flags", {29'd0, wb_en, zero, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd3, 0);
        issue(4'd1, 32'd5, 32'd5, 5'd7, 0);
        issue(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd4, 0);
        issue(4'd8, 32'h8000_0000, 32'd4, 5'd5, 0);
        issue(4'd7, 32'h8000_0000, 32'd4, 5'd6, 0);
        issue(4'd6, 32'h8000_0000, 32'd4, 5'd8, 0);
        issue(4'd6, 32'h1234_5678, 32'hFFFF_FFE0, 5'd9, 0);
        issue(4'd9, 32'h0001_0003, 32'h0002_0005, 5'd10, 8);
        issue(4'd10, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 0);
        issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 0);
        issue(4'd1, 32'h8000_0000, 32'd1, 5'd12, 0);

        // Abort a multiply after ten iterations.
        issue(4'd9, 32'hFFFF_FFFF, 32'h0000_0003, 5'd13, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("abort_flags", {29'd0, wb_en, zero, ovf}, 32'd0);
        repeat (40) @(negedge clk);
        issue(4'd0, 32'd2, 32'd3, 5'd1, 0);

        for (int i = 0; i < 200; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            issue(o, pick(), pick(), 5'($urandom), (o == 4'd9 && $urandom_range(0, 1) == 1) ? 5 : 0);
        end

        begin
            int g = 0;
            while (q.size() != 0 && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
